// File: rtl/wb_arbiter.sv
// Writeback arbiter: EXU/LSU one-entry buffers, round-robin onto a registered
// register-file write port, plus a per-register pending-write scoreboard.

module wb_src_buf #(
  parameter int W = 37
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         valid,
  input  logic [W-1:0] din,
  input  logic         gnt,
  output logic         ready,
  output logic         v,
  output logic [W-1:0] q
);
  // Ready looks only at buffer state, so a grant frees the slot for a same-edge refill.
  assign ready = !v | gnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v <= 1'b0;
      q <= '0;
    end else if (valid && ready) begin
      v <= 1'b1;
      q <= din;
    end else if (gnt) begin
      v <= 1'b0;
    end
  end
endmodule

module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            exu_valid_i,
  output logic            exu_ready_o,
  input  logic [RW-1:0]   exu_rd_i,
  input  logic [XLEN-1:0] exu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [RW-1:0]   lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            alloc_valid_i,
  input  logic [RW-1:0]   alloc_rd_i,
  output logic [NREG-1:0] busy_o,
  output logic            wen_o,
  output logic [RW-1:0]   rd_o,
  output logic [XLEN-1:0] wdata_o
);
  // Source index 0 is LSU, 1 is EXU; this matches the rr encoding.
  localparam int NSRC = 2;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  localparam int W = $bits(wb_req_t);

  logic    [NSRC-1:0] in_v, rdy, buf_v, gnt;
  wb_req_t [NSRC-1:0] in_req, buf_req;
  wb_req_t            win_req;
  logic               win, rr, any_gnt;
  logic    [NREG-1:0] busy, busy_nxt;

  assign in_v   = {exu_valid_i, lsu_valid_i};
  assign in_req = {{exu_rd_i, exu_data_i}, {lsu_rd_i, lsu_data_i}};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    wb_src_buf #(.W(W)) u_buf (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .valid  (in_v[g]),
      .din    (in_req[g]),
      .gnt    (gnt[g]),
      .ready  (rdy[g]),
      .v      (buf_v[g]),
      .q      (buf_req[g])
    );
  end

  assign lsu_ready_o = rdy[0];
  assign exu_ready_o = rdy[1];

  always_comb begin
    win = buf_v[1];
    if (&buf_v) win = rr;
    any_gnt = |buf_v;
    gnt = '0;
    if (any_gnt) gnt[win] = 1'b1;
  end

  assign win_req = buf_req[win];

  // Set beats clear: a same-edge alloc means a newer producer is now in flight.
  always_comb begin
    busy_nxt = busy;
    if (any_gnt && win_req.rd != '0) busy_nxt[win_req.rd] = 1'b0;
    if (alloc_valid_i && alloc_rd_i != '0) busy_nxt[alloc_rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr      <= 1'b0;
      busy    <= '0;
      wen_o   <= 1'b0;
      rd_o    <= '0;
      wdata_o <= '0;
    end else begin
      busy  <= busy_nxt;
      wen_o <= 1'b0;
      if (any_gnt) begin
        rr      <= ~win;
        rd_o    <= win_req.rd;
        wdata_o <= win_req.data;
        wen_o   <= (win_req.rd != '0);
      end
    end
  end

  assign busy_o = busy;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: cycle vector table, hand sequences for reset and
// backpressure, and a commit scoreboard for the streaming/contention traffic.

module tb_wb_arbiter;
  localparam int XLEN = 32, NREG = 32, RW = 5;

  logic            clk = 1'b0, rst_n;
  logic            exu_valid, exu_ready, lsu_valid, lsu_ready, alloc_valid, wen;
  logic [RW-1:0]   exu_rd, lsu_rd, alloc_rd, rd;
  logic [XLEN-1:0] exu_data, lsu_data, wdata;
  logic [NREG-1:0] busy;

  wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .RW(RW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .exu_valid_i(exu_valid), .exu_ready_o(exu_ready), .exu_rd_i(exu_rd), .exu_data_i(exu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
    .alloc_valid_i(alloc_valid), .alloc_rd_i(alloc_rd), .busy_o(busy),
    .wen_o(wen), .rd_o(rd), .wdata_o(wdata)
  );

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } res_t;

  res_t exp_q[$], exu_q[$], lsu_q[$];
  bit   sb_on = 1'b0;
  logic last_exu_rdy, last_lsu_rdy;

  // Scoreboard: every wen pulse must match the oldest expected commit.
  always @(negedge clk) begin
    res_t e;
    if (sb_on && rst_n && wen) begin
      if (exp_q.size() == 0) check("sb_unexpected_wen", wen, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("sb_rd", rd, e.rd);
        check("sb_data", wdata, e.data);
      end
    end
  end

  task automatic idle_inputs();
    exu_valid = 0; exu_rd = '0; exu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    alloc_valid = 0; alloc_rd = '0;
  endtask

  // Called at a negedge: present queue heads, take the edge, pop on handshake.
  task automatic cycle();
    idle_inputs();
    if (exu_q.size() > 0) begin exu_valid = 1; exu_rd = exu_q[0].rd; exu_data = exu_q[0].data; end
    if (lsu_q.size() > 0) begin lsu_valid = 1; lsu_rd = lsu_q[0].rd; lsu_data = lsu_q[0].data; end
    #1;
    last_exu_rdy = exu_ready;
    last_lsu_rdy = lsu_ready;
    @(posedge clk);
    if (exu_valid && last_exu_rdy) void'(exu_q.pop_front());
    if (lsu_valid && last_lsu_rdy) void'(lsu_q.pop_front());
    @(negedge clk);
  endtask

  typedef struct {
    logic ev; logic [RW-1:0] erd; logic [XLEN-1:0] ed;
    logic lv; logic [RW-1:0] lrd; logic [XLEN-1:0] ld;
    logic av; logic [RW-1:0] ard;
    logic xer, xlr, xwen; logic [RW-1:0] xrd; logic [XLEN-1:0] xd; logic [NREG-1:0] xbusy;
  } vec_t;

  vec_t vt[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ready expectations are sampled before the edge; wen/rd/wdata/busy after it
    vt[0]  = '{0, 0,  0,    0, 0, 0,      1, 10, 1, 1, 0, 0,  0,      32'h1 << 10};
    vt[1]  = '{1, 10, 'hA,  0, 0, 0,      0, 0,  1, 1, 0, 0,  0,      32'h1 << 10};
    vt[2]  = '{0, 0,  0,    0, 0, 0,      1, 10, 1, 1, 1, 10, 'hA,    32'h1 << 10};
    vt[3]  = '{1, 10, 'hB,  0, 0, 0,      0, 0,  1, 1, 0, 10, 'hA,    32'h1 << 10};
    vt[4]  = '{0, 0,  0,    0, 0, 0,      0, 0,  1, 1, 1, 10, 'hB,    32'h0};
    vt[5]  = '{0, 0,  0,    1, 0, 'h1234, 1, 0,  1, 1, 0, 10, 'hB,    32'h0};
    vt[6]  = '{0, 0,  0,    0, 0, 0,      0, 0,  1, 1, 0, 0,  'h1234, 32'h0};
    vt[7]  = '{1, 3,  'h33, 1, 7, 'h77,   1, 7,  1, 1, 0, 0,  'h1234, 32'h1 << 7};
    vt[8]  = '{0, 0,  0,    0, 0, 0,      0, 0,  1, 0, 1, 3,  'h33,   32'h1 << 7};
    vt[9]  = '{0, 0,  0,    0, 0, 0,      0, 0,  1, 1, 1, 7,  'h77,   32'h0};
    vt[10] = '{0, 0,  0,    0, 0, 0,      0, 0,  1, 1, 0, 7,  'h77,   32'h0};

    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_exu_ready", exu_ready, 1'b1);
    check("rst_lsu_ready", lsu_ready, 1'b1);
    check("rst_wen", wen, 1'b0);
    check("rst_rd", rd, '0);
    check("rst_wdata", wdata, '0);
    check("rst_busy", busy, '0);
    @(negedge clk);

    // Scoreboard set/clear, set-wins, x0, and round-robin pointer effects.
    for (int i = 0; i < 11; i++) begin
      exu_valid = vt[i].ev; exu_rd = vt[i].erd; exu_data = vt[i].ed;
      lsu_valid = vt[i].lv; lsu_rd = vt[i].lrd; lsu_data = vt[i].ld;
      alloc_valid = vt[i].av; alloc_rd = vt[i].ard;
      #1;
      check($sformatf("vec%0d_exu_ready", i), exu_ready, vt[i].xer);
      check($sformatf("vec%0d_lsu_ready", i), lsu_ready, vt[i].xlr);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_wen", i), wen, vt[i].xwen);
      check($sformatf("vec%0d_rd", i), rd, vt[i].xrd);
      check($sformatf("vec%0d_wdata", i), wdata, vt[i].xd);
      check($sformatf("vec%0d_busy", i), busy, vt[i].xbusy);
    end
    idle_inputs();

    // Reset mid-stream with both buffers full and a commit on the port.
    alloc_valid = 1; alloc_rd = 4;
    exu_valid = 1; exu_rd = 1; exu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    @(posedge clk); @(negedge clk);
    check("midrst_pre_wen", wen, 1'b1);
    check("midrst_pre_busy", busy, 32'h1 << 4);
    #2 rst_n = 0;
    #1;
    check("midrst_wen", wen, 1'b0);
    check("midrst_busy", busy, '0);
    check("midrst_exu_ready", exu_ready, 1'b1);
    check("midrst_lsu_ready", lsu_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;
    exu_valid = 1; exu_rd = 3; exu_data = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    exu_valid = 0;
    check("lat_e0_wen", wen, 1'b0);
    @(posedge clk); @(negedge clk);
    check("lat_e1_wen", wen, 1'b1);
    check("lat_e1_rd", rd, 3);
    check("lat_e1_wdata", wdata, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    check("lat_e2_wen", wen, 1'b0);

    // Contention: LSU favoured first, then strict alternation.
    sb_on = 1;
    for (int i = 0; i < 4; i++) begin
      exu_q.push_back('{RW'(1 + i), 32'hE000 + i});
      lsu_q.push_back('{RW'(5 + i), 32'hC000 + i});
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{RW'(5 + i), 32'hC000 + i});
      exp_q.push_back('{RW'(1 + i), 32'hE000 + i});
    end
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (c >= 1) begin
        check($sformatf("cont%0d_exu_ready", c), last_exu_rdy, (c % 2) == 0);
        check($sformatf("cont%0d_lsu_ready", c), last_lsu_rdy, (c % 2) == 1);
      end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle();
    cycle(); cycle();
    check("cont_all_committed", exp_q.size(), 0);

    // Single streaming source: one commit per cycle, ready stays high.
    for (int i = 0; i < 8; i++) begin
      exu_q.push_back('{RW'(11 + i), 32'h1000 + i});
      exp_q.push_back('{RW'(11 + i), 32'h1000 + i});
    end
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (c < 8) check($sformatf("stream%0d_exu_ready", c), last_exu_rdy, 1'b1);
      if (c >= 1 && c <= 8) check($sformatf("stream%0d_wen", c), wen, 1'b1);
      if (c == 9) check("stream_end_wen", wen, 1'b0);
    end
    check("stream_all_committed", exp_q.size(), 0);
    sb_on = 0;

    // Backpressure: LSU full and losing, upstream data changes illegally.
    idle_inputs();
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h0;
    @(posedge clk); @(negedge clk);
    lsu_valid = 0;
    @(posedge clk); @(negedge clk);
    exu_valid = 1; exu_rd = 21; exu_data = 32'h21;
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h100;
    @(posedge clk); @(negedge clk);
    exu_valid = 0;
    lsu_data = 32'hBAD;
    #1;
    check("bp_lsu_ready_low", lsu_ready, 1'b0);
    check("bp_exu_ready", exu_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    check("bp_exu_wen", wen, 1'b1);
    check("bp_exu_rd", rd, 21);
    lsu_valid = 0;
    @(posedge clk); @(negedge clk);
    check("bp_lsu_wen", wen, 1'b1);
    check("bp_lsu_rd", rd, 20);
    check("bp_lsu_wdata", wdata, 32'h100);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and pending-register scoreboard that drives the register file's single write port. It merges results from the execute unit (EXU) and load/store unit (LSU) through per-source one-entry buffers with valid/ready handshakes, and round-robin arbitrates them onto a registered write port (`wen_o`/`rd_o`/`wdata_o`). It also tracks which architectural registers have an in-flight write, so decode can stall on read-after-write hazards.

## Interface
Parameters:
- `XLEN`, 32, data width of a register.
- `NREG`, 32, number of architectural registers.
- `RW`, 5, register index width (`$clog2(NREG)`).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `exu_valid_i`  in  1  EXU result valid.
- `exu_ready_o`  out  1  EXU buffer can accept.
- `exu_rd_i`  in  RW  EXU destination register.
- `exu_data_i`  in  XLEN  EXU result.
- `lsu_valid_i`  in  1  LSU result valid.
- `lsu_ready_o`  out  1  LSU buffer can accept.
- `lsu_rd_i`  in  RW  LSU destination register.
- `lsu_data_i`  in  XLEN  LSU load data.
- `alloc_valid_i`  in  1  decode issued an instruction writing `alloc_rd_i`.
- `alloc_rd_i`  in  RW  register to mark pending.
- `busy_o`  out  NREG  per-register pending-write vector. Bit 0 is always 0.
- `wen_o`  out  1  register file write enable (registered).
- `rd_o`  out  RW  register file write index (registered).
- `wdata_o`  out  XLEN  register file write data (registered).

## Operation
- Each source has a one-entry buffer `{v, rd, data}`.
  - Handshake: `valid_i & ready_o` at a rising edge loads the buffer.
  - `ready_o = !buf_v | grant_src`. It depends only on buffer state and pointer, never on `valid_i`.
  - Simultaneous grant and load refills the buffer at the same edge, giving back-to-back acceptance.
- Arbitration (combinational, from buffer state only):
  - One buffer valid: that buffer wins.
  - Both valid: the source indicated by the round-robin pointer `rr` wins. `rr=0` means LSU, `rr=1` means EXU.
  - After any grant, `rr` points to the non-winning source.
- Output register, on each edge:
  - With a grant: `rd_o`/`wdata_o` load the winner's fields, and `wen_o = (winner rd != 0)`.
  - Without a grant: `wen_o` goes to 0, and `rd_o`/`wdata_o` hold their values.
  - `wen_o` is therefore a one-cycle pulse per committed result.
- x0 handling: results with `rd = 0` are accepted and granted normally (they consume an arbitration slot) but never assert `wen_o`.
- Scoreboard `busy[NREG-1:0]`:
  - Set: at an edge with `alloc_valid_i` and `alloc_rd_i != 0`, `busy[alloc_rd_i] <= 1`.
  - Clear: at the edge where a winner with `rd != 0` is registered, `busy[winner rd] <= 0`.
  - Same register set and cleared at the same edge: set wins (the new producer is pending).
  - `busy[0]` is constant 0.
- No reordering within a source; results leave each source in acceptance order.

## Timing
- Reset (async assert, any time):
  - Both buffers empty; both `ready_o = 1`.
  - `wen_o = 0`, `rd_o = 0`, `wdata_o = 0`, `busy_o = 0`, `rr = 0` (LSU favoured first).
  - Buffered, in-flight results are discarded.
  - Deassertion is taken synchronously to `clk_i` by the surrounding reset logic; the first accept can occur at the first edge after deassertion.
- Latency:
  - Handshake at edge E0 → buffer valid.
  - Granted in the following cycle → `wen_o` high after edge E1.
  - Register file writes at E2.
  - With an uncontended source, handshake to `wen_o` is 1 cycle.
- `busy` clears at E1, the same edge `wen_o` rises. `src` data must be bypassed or read after E2 by the consumer.
- Throughput: at most one commit per cycle in total.
  - A single streaming source sustains 1 result per cycle.
  - Two streaming sources get 1 result every 2 cycles each, strictly alternating.
- Backpressure: a source with an ungranted full buffer holds `ready_o = 0`; its upstream must hold `valid`/`rd`/`data` stable.

## Test plan
- Reset, idle: assert `rst_n_i=0` mid-stream with both buffers full → immediately `wen_o=0`, `busy_o=0`, both `ready_o=1`. After release, a single EXU result (`rd=3`, `data=0xDEADBEEF`) gives `wen_o=1`, `rd_o=3`, `wdata_o=0xDEADBEEF` exactly one cycle after the handshake, for exactly one cycle.
- Contention: both sources valid every cycle (EXU `rd=1..4`, LSU `rd=5..8`) → the first commit is LSU `rd=5`, then strict alternation 1,6,2,7,…. Each `ready_o` is high every other cycle, and no result is lost or duplicated.
- Streaming single source: EXU valid for 8 consecutive cycles, LSU idle → 8 consecutive `wen_o` pulses, `exu_ready_o` constantly 1, order preserved.
- x0: LSU result with `rd=0`, `data=0x1234` → accepted and consumes one slot, `wen_o` stays 0, `busy_o` unchanged.
- Scoreboard: alloc `rd=10` → `busy_o[10]=1` next cycle. An EXU result for `rd=10` clears it at the edge `wen_o` rises. Alloc `rd=10` at that same edge → `busy_o[10]` stays 1. Alloc `rd=0` → `busy_o[0]` stays 0.
- Backpressure hold: LSU buffer full and losing arbitration with `lsu_valid_i` held high and changing data upstream-illegal → checker confirms `lsu_ready_o=0` until grant, and the buffered data, not the input, is written.
